// File: rtl/mod_div_seq.sv
// Sequential restoring divider: one quotient bit per clock through a single shared subtractor.
// q/r/div_zero are loaded on the edge that enters DONE and hold until the next result.
module mod_div_seq #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] q,
  output logic [N-1:0] r,
  output logic         div_zero
);
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t        r_state, w_state_n;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_dvd, r_dvs, r_q, r_r;
  logic [N:0]    r_rem;
  logic          r_dz;

  logic [N:0]    w_t, w_diff, w_rem_n;
  logic [N-1:0]  w_dvd_n;
  logic          w_ge, w_last;

  // Quotient bits shift into the dividend register's LSB as its MSBs are consumed.
  always_comb begin
    w_t     = (r_rem << 1) | {{N{1'b0}}, r_dvd[N-1]};
    w_ge    = (w_t >= {1'b0, r_dvs});
    w_diff  = w_t - {1'b0, r_dvs};
    w_rem_n = w_ge ? w_diff : w_t;
    w_dvd_n = {r_dvd[N-2:0], w_ge};
    w_last  = (r_cnt == CW'(N-1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    busy      = 1'b0;
    done      = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_state_n = (b == '0) ? S_DONE : S_CALC;
      S_CALC: begin
        busy = 1'b1;
        if (w_last) w_state_n = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_dvd <= '0;
      r_dvs <= '0;
      r_rem <= '0;
      r_q   <= '0;
      r_r   <= '0;
      r_dz  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_dvd <= a;
          r_dvs <= b;
          r_rem <= '0;
          r_cnt <= '0;
          if (b == '0) begin
            r_q  <= '1;
            r_r  <= a;
            r_dz <= 1'b1;
          end
        end
        S_CALC: begin
          r_rem <= w_rem_n;
          r_dvd <= w_dvd_n;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_q  <= w_dvd_n;
            r_r  <= w_rem_n[N-1:0];
            r_dz <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign q        = r_q;
  assign r        = r_r;
  assign div_zero = r_dz;
endmodule
